// File: rtl/matrix_data_memory.sv
// Operand/result matrix store (A, B, C) behind a valid/ready port with registered responses,
// plus a hardware clear sweep of C and a streaming dump of C for the display path.
//
//   state   | meaning
//   S_IDLE  | serving requests; clear_c / dump_start start a sweep
//   S_CLEAR | zeroing C one word per cycle, requests stalled
//   S_DUMP  | streaming C one word per cycle on the dump port
module matrix_data_memory #(
    parameter int              DW     = 32,
    parameter int              AW     = 32,
    parameter int              N      = 3,
    parameter logic [AW-1:0]   A_BASE = 'h200,
    parameter logic [AW-1:0]   B_BASE = 'h300,
    parameter logic [AW-1:0]   C_BASE = 'h100,
    parameter logic [DW-1:0]   A_INIT = 1024,
    parameter logic [DW-1:0]   B_INIT = 256,
    parameter bit              WR_AB  = 1'b0,
    localparam int             NW     = N * N,
    localparam int             IW     = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    input  logic          clear_c_i,
    input  logic          dump_start_i,
    output logic          dump_valid_o,
    output logic [IW-1:0] dump_idx_o,
    output logic [DW-1:0] dump_data_o,
    output logic          busy_o
);

    localparam logic [AW-1:0] SPAN = AW'(4 * NW);
    localparam logic [IW-1:0] LAST = IW'(NW - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DUMP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem_a_q [NW];
    logic [DW-1:0] mem_b_q [NW];
    logic [DW-1:0] mem_c_q [NW];

    logic          rsp_valid_q, rsp_err_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_err_d;
    logic [DW-1:0] rsp_rdata_d;

    logic          dump_valid_q, dump_valid_d;
    logic [IW-1:0] dump_idx_q, dump_idx_d;
    logic [DW-1:0] dump_data_q, dump_data_d;

    logic          hit_a, hit_b, hit_c, acc_err, accept;
    logic          wr_a, wr_b, wr_c, clr_wr;
    logic [IW-1:0] idx_a, idx_b, idx_c;

    function automatic logic in_region(input logic [AW-1:0] addr, input logic [AW-1:0] base);
        return (addr >= base) && ((addr - base) < SPAN) && (addr[1:0] == 2'b00);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] addr, input logic [AW-1:0] base);
        return IW'((addr - base) >> 2);
    endfunction

    always_comb begin
        hit_a   = in_region(req_addr_i, A_BASE);
        hit_b   = in_region(req_addr_i, B_BASE);
        hit_c   = in_region(req_addr_i, C_BASE);
        idx_a   = word_idx(req_addr_i, A_BASE);
        idx_b   = word_idx(req_addr_i, B_BASE);
        idx_c   = word_idx(req_addr_i, C_BASE);
        // A/B writes are protection errors unless the instance makes them writable
        acc_err = !(hit_a || hit_b || hit_c) ||
                  (req_we_i && !hit_c && (hit_a || hit_b) && !WR_AB);
        accept  = req_valid_i && req_ready_o;
        wr_c    = accept && req_we_i && hit_c;
        wr_a    = accept && req_we_i && !hit_c && hit_a && WR_AB;
        wr_b    = accept && req_we_i && !hit_c && !hit_a && hit_b && WR_AB;

        rsp_err_d   = accept && acc_err;
        rsp_rdata_d = '0;
        if (accept && !req_we_i && !acc_err) begin
            if (hit_c)      rsp_rdata_d = mem_c_q[idx_c];
            else if (hit_a) rsp_rdata_d = mem_a_q[idx_a];
            else            rsp_rdata_d = mem_b_q[idx_b];
        end
    end

    assign req_ready_o = (state_q == S_IDLE) && !clear_c_i && !dump_start_i;
    assign busy_o      = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clr_wr       = 1'b0;
        dump_valid_d = 1'b0;
        dump_idx_d   = '0;
        dump_data_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (clear_c_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (dump_start_i) begin
                    state_d = S_DUMP;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                clr_wr = 1'b1;
                if (cnt_q == LAST) state_d = S_IDLE;
                else               cnt_d   = cnt_q + IW'(1);
            end
            S_DUMP: begin
                dump_valid_d = 1'b1;
                dump_idx_d   = cnt_q;
                dump_data_d  = mem_c_q[cnt_q];
                if (cnt_q == LAST) state_d = S_IDLE;
                else               cnt_d   = cnt_q + IW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            for (int i = 0; i < NW; i++) begin
                mem_a_q[i] <= A_INIT;
                mem_b_q[i] <= B_INIT;
                mem_c_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= accept;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            if (wr_a) mem_a_q[idx_a] <= req_wdata_i;
            if (wr_b) mem_b_q[idx_b] <= req_wdata_i;
            // the sweep and request writes never coincide: req_ready is low outside IDLE
            if (clr_wr)     mem_c_q[cnt_q] <= '0;
            else if (wr_c)  mem_c_q[idx_c] <= req_wdata_i;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_err_o    = rsp_err_q;
    assign dump_valid_o = dump_valid_q;
    assign dump_idx_o   = dump_idx_q;
    assign dump_data_o  = dump_data_q;

endmodule

// File: tb/tb_matrix_data_memory.sv
// Directed bench for matrix_data_memory: a 3x3 instance for the main sequence and a 4x4
// instance for the larger dump.
module tb_matrix_data_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_we = 0, clear_c = 0, dump_start = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err, dump_valid, busy;
    logic [31:0] rsp_rdata, dump_data;
    logic [3:0]  dump_idx;

    logic        q_valid = 0, q_we = 0, q_clear = 0, q_dump = 0;
    logic [31:0] q_addr = 0, q_wdata = 0;
    logic        q_ready, q_rvalid, q_err, q_dvalid, q_busy;
    logic [31:0] q_rdata, q_ddata;
    logic [3:0]  q_didx;

    int checks = 0;
    int errors = 0;
    logic [31:0] c_exp [9];
    int busy_cnt;

    matrix_data_memory #(.N(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .clear_c_i(clear_c), .dump_start_i(dump_start),
        .dump_valid_o(dump_valid), .dump_idx_o(dump_idx), .dump_data_o(dump_data),
        .busy_o(busy)
    );

    matrix_data_memory #(.N(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(q_valid), .req_ready_o(q_ready), .req_we_i(q_we),
        .req_addr_i(q_addr), .req_wdata_i(q_wdata),
        .rsp_valid_o(q_rvalid), .rsp_rdata_o(q_rdata), .rsp_err_o(q_err),
        .clear_c_i(q_clear), .dump_start_i(q_dump),
        .dump_valid_o(q_dvalid), .dump_idx_o(q_didx), .dump_data_o(q_ddata),
        .busy_o(q_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr,
                      input logic [31:0] exp_data, input logic exp_err);
        req_valid = 1; req_we = 0; req_addr = addr;
        tick();
        req_valid = 0;
        chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_dat"}, rsp_rdata, exp_data);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    endtask

    task automatic wr(input string tag, input logic [31:0] addr,
                      input logic [31:0] data, input logic exp_err);
        req_valid = 1; req_we = 1; req_addr = addr; req_wdata = data;
        tick();
        req_valid = 0; req_we = 0;
        chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_dat"}, rsp_rdata, 32'd0);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    endtask

    task automatic dump3(input string tag);
        dump_start = 1;
        tick();
        dump_start = 0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk({tag, "_dv"}, {31'd0, dump_valid}, 32'd1);
            chk({tag, "_idx"}, {28'd0, dump_idx}, k);
            chk({tag, "_data"}, dump_data, c_exp[k]);
        end
        tick();
        chk({tag, "_dv_end"}, {31'd0, dump_valid}, 32'd0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) c_exp[i] = 0;

        // 1: reset state and initial contents
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rvld", {31'd0, rsp_valid}, 32'd0);
        chk("rst_dvld", {31'd0, dump_valid}, 32'd0);
        #10 rst_n = 1;
        tick();
        rd("rd_a0", 32'h200, 32'd1024, 1'b0);
        rd("rd_a8", 32'h220, 32'd1024, 1'b0);
        rd("rd_b0", 32'h300, 32'd256, 1'b0);
        rd("rd_b8", 32'h320, 32'd256, 1'b0);
        rd("rd_a_end", 32'h224, 32'd0, 1'b1);
        chk("idle_rvld", {31'd0, rsp_valid}, 32'd1);
        tick();
        chk("idle_rvld_drop", {31'd0, rsp_valid}, 32'd0);

        // 2: write then read back-to-back, then dump
        wr("wr_c1", 32'h104, 32'd7, 1'b0);
        rd("rd_c1", 32'h104, 32'd7, 1'b0);
        c_exp[1] = 7;
        dump3("dump1");

        // 3: error cases
        rd("err_c_end", 32'h124, 32'd0, 1'b1);
        rd("err_misal", 32'h102, 32'd0, 1'b1);
        rd("err_below", 32'h0fc, 32'd0, 1'b1);
        wr("err_wr_a", 32'h200, 32'd5, 1'b1);
        rd("a_kept", 32'h200, 32'd1024, 1'b0);

        // 4: clear sweep with a request held pending
        for (int i = 0; i < 9; i++) wr("fill", 32'h100 + 4 * i, i + 1, 1'b0);
        rd("fill_chk8", 32'h120, 32'd9, 1'b0);
        req_valid = 1; req_we = 0; req_addr = 32'h100; clear_c = 1;
        #1;
        chk("clr_ready_pulse", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        clear_c = 0;
        for (int i = 0; i < 9; i++) begin
            chk("clr_ready", {31'd0, req_ready}, 32'd0);
            chk("clr_busy", {31'd0, busy}, 32'd1);
            chk("clr_rvld", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        chk("clr_ready_back", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 0;
        chk("clr_held_vld", {31'd0, rsp_valid}, 32'd1);
        chk("clr_held_dat", rsp_rdata, 32'd0);
        for (int i = 0; i < 9; i++) rd("clr_c", 32'h100 + 4 * i, 32'd0, 1'b0);

        // 5: clear and dump requested together
        wr("wr_c2", 32'h108, 32'd3, 1'b0);
        clear_c = 1; dump_start = 1;
        tick();
        clear_c = 0; dump_start = 0;
        busy_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            chk("both_dv", {31'd0, dump_valid}, 32'd0);
            if (busy) busy_cnt++;
            tick();
        end
        chk("both_busy_cycles", busy_cnt, 32'd9);
        rd("both_c2", 32'h108, 32'd0, 1'b0);

        // 6: reset in the middle of a dump
        wr("wr_c0", 32'h100, 32'h11, 1'b0);
        wr("wr_c4", 32'h110, 32'h44, 1'b0);
        dump_start = 1;
        tick();
        dump_start = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mid_dv", {31'd0, dump_valid}, 32'd1);
            chk("mid_idx", {28'd0, dump_idx}, k);
            chk("mid_data", dump_data, (k == 0) ? 32'h11 : ((k == 4) ? 32'h44 : 32'd0));
        end
        rst_n = 0;
        #1;
        chk("mid_rst_dv", {31'd0, dump_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        #2 rst_n = 1;
        tick();
        rd("rst_c0", 32'h100, 32'd0, 1'b0);
        rd("rst_c4", 32'h110, 32'd0, 1'b0);
        rd("rst_a0", 32'h200, 32'd1024, 1'b0);

        // 6b: 4x4 instance, 16-word dump
        q_valid = 1; q_we = 1; q_addr = 32'h13c; q_wdata = 32'hf0;
        tick();
        q_addr = 32'h100; q_wdata = 32'h10;
        chk("n4_wr15_vld", {31'd0, q_rvalid}, 32'd1);
        chk("n4_wr15_err", {31'd0, q_err}, 32'd0);
        tick();
        q_we = 0; q_addr = 32'h23c;
        chk("n4_wr0_err", {31'd0, q_err}, 32'd0);
        tick();
        q_valid = 0;
        chk("n4_rd_a15", q_rdata, 32'd1024);
        chk("n4_rd_a15_err", {31'd0, q_err}, 32'd0);
        q_dump = 1;
        tick();
        q_dump = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("n4_dv", {31'd0, q_dvalid}, 32'd1);
            chk("n4_idx", {28'd0, q_didx}, k);
            chk("n4_data", q_ddata, (k == 0) ? 32'h10 : ((k == 15) ? 32'hf0 : 32'd0));
        end
        tick();
        chk("n4_dv_end", {31'd0, q_dvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
